// File: rtl/iic_init_sequencer.sv
// Walks a register-configuration table and issues one IIC single-byte write per entry,
// with per-attempt timeout and retry. Define IIC_SEQ_DELAY_CMD_EN to treat word address 8'hFE as a delay command.
module iic_init_sequencer #(
  parameter logic [6:0] C_DEV_ADDR    = 7'h21,
  parameter int         C_TABLE_LEN   = 16,
  parameter int         C_TIMEOUT_CYC = 8192,
  parameter int         C_MAX_RETRY   = 3,
  parameter int         C_GAP_CYC     = 64
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic        I_start,
  output logic [7:0]  O_rom_addr,
  input  logic [15:0] I_rom_data,
  output logic        O_iic_send_en,
  output logic [6:0]  O_dev_addr,
  output logic [7:0]  O_word_addr,
  output logic [7:0]  O_write_data,
  input  logic        I_done_flag,
  output logic        O_busy,
  output logic        O_done,
  output logic        O_error,
  output logic [7:0]  O_err_index
);

  localparam int TW = $clog2(C_TIMEOUT_CYC + 1);
  localparam int GW = $clog2(C_GAP_CYC + 1);
  localparam int RW = $clog2(C_MAX_RETRY + 2);

  localparam logic [TW-1:0] TMO_LAST  = TW'(C_TIMEOUT_CYC - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(C_GAP_CYC - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(C_MAX_RETRY);
  localparam logic [7:0]    LAST_IDX  = 8'(C_TABLE_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_SEND, S_GAP, S_FINISH, S_ERROR, S_DELAY
  } state_t;

  state_t          state;
  state_t          gap_next;
  logic [7:0]      index;
  logic [RW-1:0]   retry;
  logic [TW-1:0]   tmo_cnt;
  logic [GW-1:0]   gap_cnt;
`ifdef IIC_SEQ_DELAY_CMD_EN
  logic [17:0]     dly_cnt;
`endif

  assign O_dev_addr = C_DEV_ADDR;

  // NOTE: all state is updated with non-blocking assignments so every branch
  // sees the pre-edge values of the registers it reads.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state         <= S_IDLE;
      gap_next      <= S_IDLE;
      index         <= '0;
      retry         <= '0;
      tmo_cnt       <= '0;
      gap_cnt       <= '0;
      O_rom_addr    <= '0;
      O_iic_send_en <= 1'b0;
      O_word_addr   <= '0;
      O_write_data  <= '0;
      O_busy        <= 1'b0;
      O_done        <= 1'b0;
      O_error       <= 1'b0;
      O_err_index   <= '0;
`ifdef IIC_SEQ_DELAY_CMD_EN
      dly_cnt       <= '0;
`endif
    end else begin
      O_done <= 1'b0;
      case (state)
        S_IDLE: if (I_start) begin
          index       <= '0;
          retry       <= '0;
          O_rom_addr  <= '0;
          O_error     <= 1'b0;
          O_err_index <= '0;
          O_busy      <= 1'b1;
          state       <= S_FETCH;
        end
        S_FETCH: state <= S_LATCH;
        S_LATCH: begin
          O_word_addr  <= I_rom_data[15:8];
          O_write_data <= I_rom_data[7:0];
          if (I_rom_data == 16'hFFFF) begin
            state <= S_FINISH;
`ifdef IIC_SEQ_DELAY_CMD_EN
          end else if (I_rom_data[15:8] == 8'hFE) begin
            // Zero-length delay still spends one cycle in DELAY before advancing.
            dly_cnt <= (I_rom_data[7:0] == 8'd0) ? 18'd0 : {I_rom_data[7:0], 10'd0} - 18'd1;
            state   <= S_DELAY;
`endif
          end else begin
            O_iic_send_en <= 1'b1;
            tmo_cnt       <= '0;
            state         <= S_SEND;
          end
        end
        S_SEND: begin
          // A done arriving on the final timeout cycle takes priority.
          if (I_done_flag) begin
            O_iic_send_en <= 1'b0;
            retry         <= '0;
            gap_cnt       <= '0;
            state         <= S_GAP;
            if (index == LAST_IDX) begin
              gap_next <= S_FINISH;
            end else begin
              index    <= index + 8'd1;
              gap_next <= S_FETCH;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            O_iic_send_en <= 1'b0;
            if (retry == RETRY_MAX) begin
              state <= S_ERROR;
            end else begin
              retry    <= retry + RW'(1);
              gap_cnt  <= '0;
              gap_next <= S_SEND;
              state    <= S_GAP;
            end
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= gap_next;
            if (gap_next == S_SEND) begin
              O_iic_send_en <= 1'b1;
              tmo_cnt       <= '0;
            end else if (gap_next == S_FETCH) begin
              O_rom_addr <= index;
            end
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        S_FINISH: begin
          O_done <= 1'b1;
          O_busy <= 1'b0;
          state  <= S_IDLE;
        end
        S_ERROR: begin
          O_error     <= 1'b1;
          O_err_index <= index;
          O_busy      <= 1'b0;
          state       <= S_IDLE;
        end
`ifdef IIC_SEQ_DELAY_CMD_EN
        S_DELAY: begin
          if (dly_cnt == 18'd0) begin
            if (index == LAST_IDX) begin
              state <= S_FINISH;
            end else begin
              index      <= index + 8'd1;
              O_rom_addr <= index + 8'd1;
              state      <= S_FETCH;
            end
          end else begin
            dly_cnt <= dly_cnt - 18'd1;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iic_init_sequencer.sv
// Self-checking bench for iic_init_sequencer: directed vector table, hand sequences
// for start latency and mid-transfer reset, and randomized tables against a transaction-level model.
module tb_iic_init_sequencer;

  localparam int LEN   = 3;
  localparam int TMO   = 1024;
  localparam int RETRY = 3;
  localparam int GAP   = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        done_flag = 1'b0;
  logic [15:0] rom_data = '0;
  logic [7:0]  rom_addr, word_addr, write_data, err_index;
  logic [6:0]  dev_addr;
  logic        send_en, busy, done, error;

  always #5 clk = ~clk;

  iic_init_sequencer #(
    .C_DEV_ADDR(7'h21), .C_TABLE_LEN(LEN), .C_TIMEOUT_CYC(TMO),
    .C_MAX_RETRY(RETRY), .C_GAP_CYC(GAP)
  ) dut (
    .I_clk(clk), .I_rst_n(rst_n), .I_start(start),
    .O_rom_addr(rom_addr), .I_rom_data(rom_data),
    .O_iic_send_en(send_en), .O_dev_addr(dev_addr),
    .O_word_addr(word_addr), .O_write_data(write_data),
    .I_done_flag(done_flag), .O_busy(busy), .O_done(done),
    .O_error(error), .O_err_index(err_index)
  );

  // Synchronous table ROM: data valid one cycle after the address changes.
  logic [15:0] rom [256];
  always @(posedge clk) rom_data <= rom[rom_addr];

  int nvec = 0;
  int nmis = 0;

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Engine model + monitor. lat_plan[k] = en-high cycle on which attempt k is
  // acknowledged (0 = never answers).
  int lat_plan [16];
  int att_wa [16], att_d [16], att_len [16], att_gap [16];
  int n_att, low_cnt, done_cnt, max_rom;
  bit en_prev, mon_on, spur_on;

  always @(negedge clk) begin
    if (mon_on) begin
      if (done) done_cnt++;
      if (int'(rom_addr) > max_rom) max_rom = int'(rom_addr);
      if (send_en && !en_prev && n_att < 16) begin
        att_wa[n_att]  = int'(word_addr);
        att_d[n_att]   = int'(write_data);
        att_gap[n_att] = low_cnt;
        att_len[n_att] = 0;
        n_att++;
      end
      if (send_en) begin
        att_len[n_att-1]++;
        low_cnt = 0;
        done_flag = (att_len[n_att-1] == lat_plan[n_att-1]);
      end else begin
        low_cnt++;
        done_flag = spur_on && ($urandom_range(15) == 0);
      end
    end else begin
      done_flag = 1'b0;
    end
    en_prev = send_en;
  end

  // Transaction-level reference: per entry, up to 1+RETRY attempts; an attempt
  // succeeds if acknowledged within TMO en-high cycles.
  logic [15:0] tbl_cur [LEN];
  int e_n, e_done, e_err, e_eidx, e_maxidx;
  int e_wa [16], e_d [16], e_len [16], e_gap [16];

  task automatic model();
    int a;
    bit ok;
    a = 0; e_n = 0; e_done = 0; e_err = 0; e_eidx = 0; e_maxidx = 0;
    for (int i = 0; i < LEN; i++) begin
      e_maxidx = i;
      if (tbl_cur[i] == 16'hFFFF) begin
        e_done = 1;
        return;
      end
      ok = 1'b0;
      for (int r = 0; r <= RETRY && !ok; r++) begin
        e_wa[e_n]  = int'(tbl_cur[i][15:8]);
        e_d[e_n]   = int'(tbl_cur[i][7:0]);
        e_gap[e_n] = (e_n == 0) ? -1 : ((r == 0) ? GAP + 2 : GAP);
        if (lat_plan[a] >= 1 && lat_plan[a] <= TMO) begin
          e_len[e_n] = lat_plan[a];
          ok = 1'b1;
        end else begin
          e_len[e_n] = TMO;
        end
        a++;
        e_n++;
      end
      if (!ok) begin
        e_err = 1;
        e_eidx = i;
        return;
      end
    end
    e_done = 1;
  endtask

  task automatic arm();
    for (int i = 0; i < 256; i++) rom[i] = (i < LEN) ? tbl_cur[i] : 16'h0000;
    n_att = 0; done_cnt = 0; max_rom = 0; low_cnt = 0;
    mon_on = 1'b1;
  endtask

  task automatic run(input string tag, input bit poke);
    int k;
    arm();
    model();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    max_rom = 0;
    check({tag, ".accept_busy"}, int'(busy), 1);
    check({tag, ".accept_err_clr"}, int'(error), 0);
    if (e_n > 0) begin
      k = 1;
      while (!send_en && k < 10) begin @(negedge clk); k++; end
      check({tag, ".start_to_en"}, k, 3);
      if (poke) begin
        repeat (2) @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
      end
    end
    k = 0;
    while (busy && k < 30000) begin @(negedge clk); k++; end
    check({tag, ".busy_released"}, int'(busy), 0);
    repeat (4) @(negedge clk);
    check({tag, ".attempts"}, n_att, e_n);
    for (int i = 0; i < n_att && i < e_n; i++) begin
      check($sformatf("%s.wa%0d", tag, i), att_wa[i], e_wa[i]);
      check($sformatf("%s.wd%0d", tag, i), att_d[i], e_d[i]);
      check($sformatf("%s.len%0d", tag, i), att_len[i], e_len[i]);
      if (e_gap[i] >= 0) check($sformatf("%s.gap%0d", tag, i), att_gap[i], e_gap[i]);
    end
    check({tag, ".done_pulses"}, done_cnt, e_done);
    check({tag, ".error"}, int'(error), e_err);
    if (e_err != 0) check({tag, ".err_index"}, int'(err_index), e_eidx);
    check({tag, ".max_rom_addr"}, max_rom, e_maxidx);
    mon_on = 1'b0;
  endtask

  typedef struct packed {
    logic [0:2][15:0]  tbl;
    logic [0:11][15:0] lat;
    logic [7:0]        exp_att;
    logic              exp_done;
    logic              exp_err;
    logic [7:0]        exp_eidx;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{tbl: {16'h1280, 16'h1101, 16'h0C00}, lat: {16'd5, 16'd10, 16'd20, {9{16'd0}}},
                exp_att: 8'd3, exp_done: 1'b1, exp_err: 1'b0, exp_eidx: 8'd0};
    vecs[1] = '{tbl: {16'h1280, 16'h1101, 16'h0C00}, lat: {16'd7, {11{16'd0}}},
                exp_att: 8'd5, exp_done: 1'b0, exp_err: 1'b1, exp_eidx: 8'd1};
    vecs[2] = '{tbl: {16'h1280, 16'h1101, 16'h0C00}, lat: {16'd0, 16'd0, 16'd9, 16'd4, 16'd6, {7{16'd0}}},
                exp_att: 8'd5, exp_done: 1'b1, exp_err: 1'b0, exp_eidx: 8'd0};
    vecs[3] = '{tbl: {16'h1280, 16'hFFFF, 16'h3333}, lat: {16'd3, {11{16'd0}}},
                exp_att: 8'd1, exp_done: 1'b1, exp_err: 1'b0, exp_eidx: 8'd0};
    vecs[4] = '{tbl: {16'h1280, 16'h1101, 16'h0C00}, lat: {16'd1024, 16'd1025, 16'd1, 16'd1, {8{16'd0}}},
                exp_att: 8'd4, exp_done: 1'b1, exp_err: 1'b0, exp_eidx: 8'd0};
    vecs[5] = '{tbl: {16'hA5C3, 16'h0001, 16'hFE10}, lat: {16'd0, 16'd0, 16'd0, 16'd2, 16'd2, 16'd2, {6{16'd0}}},
                exp_att: 8'd6, exp_done: 1'b1, exp_err: 1'b0, exp_eidx: 8'd0};
    vecs[6] = '{tbl: {16'hFFFF, 16'h1280, 16'h1101}, lat: {12{16'd0}},
                exp_att: 8'd0, exp_done: 1'b1, exp_err: 1'b0, exp_eidx: 8'd0};
    vecs[7] = '{tbl: {16'h3C5A, 16'h0000, 16'hFFFF}, lat: {12{16'd0}},
                exp_att: 8'd4, exp_done: 1'b0, exp_err: 1'b1, exp_eidx: 8'd0};

    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    for (int i = 0; i < 16; i++) lat_plan[i] = 0;
    mon_on = 1'b0; spur_on = 1'b0;

    // Reset values.
    #1;
    check("rst_en", int'(send_en), 0);
    check("rst_dev_addr", int'(dev_addr), 'h21);
    check("rst_flags", int'({busy, done, error}), 0);
    check("rst_data", int'({rom_addr, word_addr, write_data, err_index}), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table; vector 1 leaves O_error set so vector 2's start must clear it.
    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < LEN; i++) tbl_cur[i] = vecs[v].tbl[i];
      for (int i = 0; i < 16; i++) lat_plan[i] = (i < 12) ? int'(vecs[v].lat[i]) : 0;
      run($sformatf("vec%0d", v), v == 0);
      check($sformatf("vec%0d.hand_attempts", v), n_att, int'(vecs[v].exp_att));
      check($sformatf("vec%0d.hand_done", v), done_cnt, int'(vecs[v].exp_done));
      check($sformatf("vec%0d.hand_error", v), int'(error), int'(vecs[v].exp_err));
      if (vecs[v].exp_err) check($sformatf("vec%0d.hand_eidx", v), int'(err_index), int'(vecs[v].exp_eidx));
    end

    // Reset during SEND of entry 2, then a fresh start from index 0.
    tbl_cur[0] = 16'h1280; tbl_cur[1] = 16'h1101; tbl_cur[2] = 16'h0C00;
    for (int i = 0; i < 16; i++) lat_plan[i] = 0;
    lat_plan[0] = 5; lat_plan[1] = 5; lat_plan[2] = 600;
    arm();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 5000 && !(n_att == 3 && send_en); k++) @(negedge clk);
    check("mid_rst.reached_entry2", n_att, 3);
    repeat (20) @(negedge clk);
    mon_on = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst.en", int'(send_en), 0);
    check("mid_rst.flags", int'({busy, done, error}), 0);
    check("mid_rst.data", int'({rom_addr, word_addr, write_data, err_index}), 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    lat_plan[0] = 4; lat_plan[1] = 4; lat_plan[2] = 4;
    run("after_rst", 1'b0);

    // Randomized tables and engine behaviour, with spurious done pulses while en is low.
    spur_on = 1'b1;
    for (int r = 0; r < 10; r++) begin
      int nev;
      nev = 0;
      for (int i = 0; i < LEN; i++)
        tbl_cur[i] = ($urandom_range(7) == 0) ? 16'hFFFF : 16'($urandom);
      for (int i = 0; i < 16; i++) begin
        if ($urandom_range(5) == 0 && nev < 3) begin
          lat_plan[i] = 0;
          nev++;
        end else if ($urandom_range(11) == 0) begin
          lat_plan[i] = TMO + int'($urandom_range(1));
        end else begin
          lat_plan[i] = int'($urandom_range(1, 80));
        end
      end
      run($sformatf("rnd%0d", r), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
